// File: rtl/led_cube_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_cube_pkg
// Purpose  : Shared constants, scanner state encoding and a counter-width
//            helper for the LED cube layer scanner.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_cube_pkg;

  localparam int NUM_LAYERS      = 8;
  localparam int BYTES_PER_LAYER = 8;
  localparam int BITS_PER_BYTE   = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    WAIT     = 3'd4,
    BLANK    = 3'd5,
    LATCH    = 3'd6
  } scan_state_t;

  // Width of a down/up counter able to hold n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_cube_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : led_cube_byte_serializer
// Purpose  : Shifts one byte MSB first onto a 74HC595-style serial string.
//            Each bit spends CLK_DIV cycles with ser_clk low followed by
//            CLK_DIV cycles with ser_clk high; data is stable across the
//            rising edge.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            load           - capture data and start a new byte
//            data[7:0]      - byte to serialise
//            half_done      - last cycle of the current ser_clk half-period
//            byte_done      - last cycle of the eighth high half-period
//            ser_clk        - shift clock
//            ser_data       - serial data (current MSB of the shift register)
// Revision : 1.0 - initial release
// ============================================================================
module led_cube_byte_serializer
  import led_cube_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [BITS_PER_BYTE-1:0] data,
  output logic                     half_done,
  output logic                     byte_done,
  output logic                     ser_clk,
  output logic                     ser_data
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(BITS_PER_BYTE - 1);

  logic                     active;
  logic [BITS_PER_BYTE-1:0] shreg;
  logic [2:0]               bit_cnt;
  logic [DIV_W-1:0]         div_cnt;

  assign half_done = active && (div_cnt == DIV_LAST);
  assign byte_done = half_done && ser_clk && (bit_cnt == BIT_LAST);
  // Driven straight from a flop, so it only moves at the start of a low phase.
  assign ser_data  = shreg[BITS_PER_BYTE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ser_clk <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      shreg   <= data;
      bit_cnt <= '0;
      div_cnt <= '0;
      ser_clk <= 1'b0;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (!ser_clk) begin
          ser_clk <= 1'b1;
        end else begin
          // End of the high phase: advance to the next bit.
          ser_clk <= 1'b0;
          shreg   <= {shreg[BITS_PER_BYTE-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_cube_layer_scanner.sv
`default_nettype none
// ============================================================================
// Module   : led_cube_layer_scanner
// Purpose  : Reads each 8-byte layer of a 64-byte cube frame, shifts it into
//            a daisy-chained column shift-register string while the previous
//            layer is lit, then blanks, latches and switches the layer drive.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            enable             - run scanning (sampled at layer boundaries)
//            data_to_latch[7:0] - frame byte at frame_addr (zero latency)
//            frame_addr[5:0]    - {layer, byte} read address
//            ser_data, ser_clk  - column serial data / shift clock
//            latch              - storage-register latch pulse
//            oe_n               - column output enable, active low
//            layer_en[7:0]      - one-hot layer drive, 0 = all off
//            frame_done         - one-cycle pulse when layer 7 is latched
//            busy               - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module led_cube_layer_scanner
  import led_cube_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int DWELL_CYCLES = 400,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [7:0]            data_to_latch,
  output logic [5:0]            frame_addr,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  latch,
  output logic                  oe_n,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int                 DWELL_W    = cnt_width(DWELL_CYCLES);
  localparam int                 CNT_W      = cnt_width((BLANK_CYCLES > CLK_DIV) ? BLANK_CYCLES : CLK_DIV);
  // Loaded with N-1 so the timer reads zero in the last lit cycle, letting
  // the blank phase start exactly DWELL_CYCLES after the layer switch.
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LATCH_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]         BYTE_LAST  = 3'(BYTES_PER_LAYER - 1);
  localparam logic [2:0]         LAYER_LAST = 3'(NUM_LAYERS - 1);

  scan_state_t        state;
  logic [2:0]         layer;
  logic [2:0]         byte_idx;
  logic [DWELL_W-1:0] dwell;
  logic [CNT_W-1:0]   cnt;
  logic               dwell_done;
  logic               half_done;
  logic               byte_done;
  logic               layer_shifted;
  logic               wait_exit;

  assign frame_addr    = {layer, byte_idx};
  assign dwell_done    = (dwell == '0);
  assign layer_shifted = (state == SHIFT_HI) && byte_done && (byte_idx == BYTE_LAST);
  // The wait phase may have zero length when shifting outlasts the dwell, so
  // the decision is also taken directly at the end of the last bit.
  assign wait_exit     = dwell_done && ((state == WAIT) || layer_shifted);

  led_cube_byte_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (state == FETCH),
    .data      (data_to_latch),
    .half_done (half_done),
    .byte_done (byte_done),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      layer      <= '0;
      byte_idx   <= '0;
      dwell      <= '0;
      cnt        <= '0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      layer_en   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!dwell_done) begin
        dwell <= dwell - 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state    <= FETCH;
            layer    <= '0;
            byte_idx <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (half_done) begin
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (byte_done) begin
            if (byte_idx != BYTE_LAST) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= FETCH;
            end else begin
              state <= WAIT;
            end
          end else if (half_done) begin
            state <= SHIFT_LO;
          end
        end
        WAIT: begin
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            latch <= 1'b1;
            state <= LATCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            cnt        <= '0;
            latch      <= 1'b0;
            oe_n       <= 1'b0;
            layer_en   <= NUM_LAYERS'(1) << layer;
            dwell      <= DWELL_LOAD;
            frame_done <= (layer == LAYER_LAST);
            layer      <= layer + 3'd1;
            byte_idx   <= '0;
            state      <= FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Overrides the WAIT entry above when the dwell has already elapsed.
      if (wait_exit) begin
        oe_n <= 1'b1;
        cnt  <= '0;
        if (enable) begin
          state <= BLANK;
        end else begin
          // Drop the freshly shifted layer and go dark.
          state    <= IDLE;
          layer_en <= '0;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
